wind_lights_n: RTL
==================

// Module: wind_lights_n
// PURPOSE
//   Parametrised successor to the 3-LED wind-indicator FSM: drives N_LEDS lights with calm,
//   sweep-down, sweep-up and bounce patterns. Adds an internal prescaler with run-time speed
//   select and a hold input. Sits under DE1_SoC, fed by CLOCK_50 directly, driving LEDR[N_LEDS-1:0].
// PARAMETERS
//   N_LEDS    3   number of lights; must be >= 3, elaboration $error otherwise
//   PRESCALE  2   base clk cycles per pattern step (>= 1); board build uses 25_000_000
// PORTS
//   clk       in   1       system clock (CLOCK_50 at top level)
//   reset_n   in   1       asynchronous, active-low reset
//   mode      in   2       00 CALM, 01 SWEEP_DOWN, 10 SWEEP_UP, 11 BOUNCE
//   speed     in   2       step period = PRESCALE << speed clk cycles
//   hold      in   1       1 = freeze prescaler and pattern
//   lights    out  N_LEDS  registered light pattern; bit N_LEDS-1 is leftmost LED
//   step      out  1       registered one-cycle pulse, high in the first cycle a new pattern shows
// BEHAVIOUR
//   One clock; reset is asynchronous and active-low. All state clears immediately on
//   reset_n=0, independent of clk, including mid-count and mid-pattern.
//   Reset values: cnt=0, cur_mode=CALM, dir=UP, lights=CALM_A, step=0.
//   CALM_A = all even-index bits set (N=3: 101); CALM_B = all odd-index bits set (N=3: 010).
//   Prescaler: cnt width = $clog2((PRESCALE<<3)+1). period = PRESCALE<<speed.
//     tick = !hold && (cnt >= period-1). On tick cnt<=0, else if !hold cnt<=cnt+1.
//     Compare is >= so a speed decrease mid-count ticks on the next cycle, never overflows.
//     hold=1: cnt, lights, cur_mode, dir frozen; step=0. hold wins over tick.
//   Mode is sampled only on tick. On tick:
//     mode != cur_mode -> cur_mode<=mode; lights<=start pattern of new mode; dir<=UP.
//     mode == cur_mode -> lights<=next pattern:
//       CALM:       CALM_A <-> CALM_B alternate.
//       SWEEP_DOWN: start 1<<(N_LEDS-1); shift right; bit 0 wraps to bit N_LEDS-1.
//       SWEEP_UP:   start 1; shift left; bit N_LEDS-1 wraps to bit 0.
//       BOUNCE:     start 1, dir UP; shift in dir; on reaching bit N_LEDS-1 dir<=DOWN,
//                   on reaching bit 0 dir<=UP; period 2*N_LEDS-2 steps, ends never doubled.
//   Defensive: if lights is not one-hot in a sweep/bounce mode, next pattern = start pattern.
//   step <= tick every cycle (registered), so step=1 exactly in the cycle new lights appear.
//   Latency: mode change visible on lights at most period cycles later, at a tick, never earlier.
// TESTING (bench: N_LEDS=3, PRESCALE=2 unless noted; speed=0 -> tick every 2nd cycle)
//   1 Reset: reset_n=0 asynchronously between edges -> lights=101, step=0 at once; release,
//     mode=00 -> lights 101,010,101 on successive ticks, step pulses every 2 cycles.
//   2 Sweep: mode=01 -> first tick 100, then 010,001,100; mode=10 -> first tick 001, then 010,100,001.
//   3 Bounce: mode=11 -> 001,010,100,010,001,010; N_LEDS=5 -> 00001..10000..00001, 8-step period.
//   4 Hold/speed: hold=1 for 7 cycles -> lights, cnt unchanged, step=0; speed=2 -> step every
//     8 cycles; drop speed 3->0 with cnt=5 -> tick on next cycle, then every 2.
//   5 Mode glitch: change mode for 1 cycle between ticks and back -> no pattern change.
//   6 Reset mid-bounce (lights=100, dir=DOWN) -> lights=101, mode CALM, dir UP after release.

Source files
------------

// File: rtl/wind_lights_n_if.sv
// Control/status bundle between a pattern source (master) and the wind_lights_n engine (slave).
// dbg_* expose the engine's mode register, bounce direction and prescaler count.
interface wind_lights_n_if #(
    parameter int N_LEDS   = 3,
    parameter int PRESCALE = 2
);
    localparam int CNT_W = $clog2((PRESCALE << 3) + 1);

    logic [1:0]        mode;
    logic [1:0]        speed;
    logic              hold;
    logic [N_LEDS-1:0] lights;
    logic              step;
    logic [1:0]        dbg_mode;
    logic              dbg_dir;
    logic [CNT_W-1:0]  dbg_cnt;

    modport master (
        output mode, speed, hold,
        input  lights, step, dbg_mode, dbg_dir, dbg_cnt
    );

    modport slave (
        input  mode, speed, hold,
        output lights, step, dbg_mode, dbg_dir, dbg_cnt
    );
endinterface

// File: rtl/wind_lights_n.sv
// N-light wind indicator: calm / sweep-down / sweep-up / bounce patterns advanced by an
// internal prescaler with run-time speed select and hold.
module wind_lights_n #(
    parameter int N_LEDS   = 3,
    parameter int PRESCALE = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    wind_lights_n_if.slave bus
);
    localparam int CNT_W = $clog2((PRESCALE << 3) + 1);

    localparam logic [1:0] MODE_CALM       = 2'b00;
    localparam logic [1:0] MODE_SWEEP_DOWN = 2'b01;
    localparam logic [1:0] MODE_SWEEP_UP   = 2'b10;
    localparam logic [1:0] MODE_BOUNCE     = 2'b11;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic logic [N_LEDS-1:0] calm_pat(input logic odd);
        logic [N_LEDS-1:0] r;
        r = '0;
        for (int i = 0; i < N_LEDS; i++) begin
            r[i] = (((i % 2) == 1) == odd);
        end
        return r;
    endfunction

    localparam logic [N_LEDS-1:0] CALM_A = calm_pat(1'b0);
    localparam logic [N_LEDS-1:0] CALM_B = calm_pat(1'b1);
    localparam logic [N_LEDS-1:0] LED_LO = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] LED_HI = {1'b1, {(N_LEDS-1){1'b0}}};

    generate
        if (N_LEDS < 3) begin : g_bad_n_leds
            $error("wind_lights_n: N_LEDS must be >= 3");
        end
        if (PRESCALE < 1) begin : g_bad_prescale
            $error("wind_lights_n: PRESCALE must be >= 1");
        end
    endgenerate

    function automatic logic [N_LEDS-1:0] start_of(input logic [1:0] m);
        logic [N_LEDS-1:0] r;
        case (m)
            MODE_CALM:       r = CALM_A;
            MODE_SWEEP_DOWN: r = LED_HI;
            default:         r = LED_LO;
        endcase
        return r;
    endfunction

    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        cur_mode_q;
    logic              dir_q;
    logic [N_LEDS-1:0] lights_q;
    logic              step_q;

    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  period_m1;
    logic              tick;

    logic [1:0]        mode_nxt;
    logic              dir_nxt;
    logic [N_LEDS-1:0] lights_nxt;
    logic              one_hot;
    logic              move_up;

    // Comparing with >= lets a speed decrease mid-count tick immediately instead of wrapping.
    always_comb begin
        period    = CNT_W'(PRESCALE) << bus.speed;
        period_m1 = period - CNT_W'(1);
        tick      = !bus.hold && (cnt_q >= period_m1);
    end

    always_comb begin
        one_hot = (lights_q != '0) && ((lights_q & (lights_q - N_LEDS'(1))) == '0);
    end

    always_comb begin
        mode_nxt   = cur_mode_q;
        dir_nxt    = dir_q;
        lights_nxt = lights_q;
        move_up    = 1'b0;
        if (bus.mode != cur_mode_q) begin
            mode_nxt   = bus.mode;
            lights_nxt = start_of(bus.mode);
            dir_nxt    = DIR_UP;
        end else begin
            case (cur_mode_q)
                MODE_CALM: begin
                    lights_nxt = (lights_q == CALM_A) ? CALM_B : CALM_A;
                end
                MODE_SWEEP_DOWN: begin
                    lights_nxt = one_hot ? {lights_q[0], lights_q[N_LEDS-1:1]} : LED_HI;
                end
                MODE_SWEEP_UP: begin
                    lights_nxt = one_hot ? {lights_q[N_LEDS-2:0], lights_q[N_LEDS-1]} : LED_LO;
                end
                default: begin
                    if (!one_hot) begin
                        lights_nxt = LED_LO;
                        dir_nxt    = DIR_UP;
                    end else begin
                        // An end bit forces the turn even if dir disagrees, so the light never drops off.
                        move_up    = (dir_q == DIR_UP) ? !lights_q[N_LEDS-1] : lights_q[0];
                        lights_nxt = move_up ? (lights_q << 1) : (lights_q >> 1);
                        if (lights_nxt[N_LEDS-1]) begin
                            dir_nxt = DIR_DOWN;
                        end else if (lights_nxt[0]) begin
                            dir_nxt = DIR_UP;
                        end else begin
                            dir_nxt = move_up ? DIR_UP : DIR_DOWN;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            cur_mode_q <= MODE_CALM;
            dir_q      <= DIR_UP;
            lights_q   <= CALM_A;
            step_q     <= 1'b0;
        end else begin
            step_q <= tick;
            if (tick) begin
                cnt_q      <= '0;
                cur_mode_q <= mode_nxt;
                dir_q      <= dir_nxt;
                lights_q   <= lights_nxt;
            end else if (!bus.hold) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.lights   = lights_q;
    assign bus.step     = step_q;
    assign bus.dbg_mode = cur_mode_q;
    assign bus.dbg_dir  = dir_q;
    assign bus.dbg_cnt  = cnt_q;

    a_lights_nonzero: assert property (@(posedge clk) disable iff (!reset_n) lights_q != '0);

endmodule
